// File: rtl/traffic_ctrl_param_if.sv
// Request inputs and lamp/debug outputs of the intersection controller.
// The slave modport faces the controller; the master modport faces whatever drives the requests.
interface traffic_ctrl_param_if;
  logic       emergency;
  logic       power_outage;
  logic       ped_req;
  logic       left_turn_req;
  logic [2:0] light1;
  logic [2:0] light2;
  logic       turn_light;
  logic       ped_walk;
  logic [3:0] state;

  modport master (
    output emergency, power_outage, ped_req, left_turn_req,
    input  light1, light2, turn_light, ped_walk, state
  );

  modport slave (
    input  emergency, power_outage, ped_req, left_turn_req,
    output light1, light2, turn_light, ped_walk, state
  );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Two-road intersection controller with pedestrian, protected left-turn, emergency and outage modes.
// Each state lasts its parameter length in clock cycles exactly; lamp outputs are registered.
module traffic_ctrl_param #(
  parameter int GREEN_CYC  = 300,
  parameter int YELLOW_CYC = 50,
  parameter int ALLRED_CYC = 25,
  parameter int PED_CYC    = 600,
  parameter int TURN_CYC   = 300,
  parameter int FLASH_CYC  = 50,
  parameter int EMERG_CYC  = 300,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_ctrl_param_if.slave  bus
);

  localparam logic [3:0] ST_G2     = 4'b0001;
  localparam logic [3:0] ST_Y2     = 4'b0010;
  localparam logic [3:0] ST_AR1    = 4'b0011;
  localparam logic [3:0] ST_G1     = 4'b0100;
  localparam logic [3:0] ST_Y1     = 4'b0101;
  localparam logic [3:0] ST_AR2    = 4'b0110;
  localparam logic [3:0] ST_PED    = 4'b0111;
  localparam logic [3:0] ST_TURN_Y = 4'b1000;
  localparam logic [3:0] ST_TURN   = 4'b1001;
  localparam logic [3:0] ST_EMERG  = 4'b1010;
  localparam logic [3:0] ST_OUTAGE = 4'b1011;

  localparam logic [2:0] LAMP_RED  = 3'b100;
  localparam logic [2:0] LAMP_YEL  = 3'b010;
  localparam logic [2:0] LAMP_GRN  = 3'b001;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  localparam logic FROM_Y2 = 1'b0;
  localparam logic FROM_Y1 = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] EMERG_LAST  = CNT_W'(EMERG_CYC - 1);

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ecnt_reg, ecnt_next;
  logic             flash_reg, flash_next;
  logic             ped_pending_reg, ped_pending_next;
  logic             ped_from_reg, ped_from_next;
  logic [2:0]       light1_reg, light1_next;
  logic [2:0]       light2_reg, light2_next;
  logic             turn_light_reg, turn_light_next;
  logic             ped_walk_reg, ped_walk_next;

  // A latched pedestrian request may cut a green short, but only after one green cycle.
  logic ped_cut;
  assign ped_cut = ped_pending_reg && (cnt_reg != CNT_ZERO);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + CNT_ONE;
    ecnt_next     = ecnt_reg;
    flash_next    = flash_reg;
    ped_from_next = ped_from_reg;

    if (bus.emergency && (state_reg != ST_EMERG)) begin
      state_next = ST_EMERG;
      ecnt_next  = CNT_ZERO;
      flash_next = 1'b1;
    end else if (bus.power_outage && (state_reg != ST_EMERG) && (state_reg != ST_OUTAGE)) begin
      state_next = ST_OUTAGE;
      flash_next = 1'b1;
    end else begin
      case (state_reg)
        ST_G2: begin
          if (ped_cut) begin
            state_next = ST_Y2;
          end else if (bus.left_turn_req && !ped_pending_reg) begin
            state_next = ST_TURN_Y;
          end else if (cnt_reg == GREEN_LAST) begin
            state_next = ST_Y2;
          end
        end
        ST_Y2: begin
          if (cnt_reg == YELLOW_LAST) begin
            if (ped_pending_reg) begin
              state_next    = ST_PED;
              ped_from_next = FROM_Y2;
            end else begin
              state_next = ST_AR1;
            end
          end
        end
        ST_AR1: begin
          if (cnt_reg == ALLRED_LAST) state_next = ST_G1;
        end
        ST_G1: begin
          if (ped_cut || (cnt_reg == GREEN_LAST)) state_next = ST_Y1;
        end
        ST_Y1: begin
          if (cnt_reg == YELLOW_LAST) begin
            if (ped_pending_reg) begin
              state_next    = ST_PED;
              ped_from_next = FROM_Y1;
            end else begin
              state_next = ST_AR2;
            end
          end
        end
        ST_AR2: begin
          if (cnt_reg == ALLRED_LAST) state_next = ST_G2;
        end
        ST_PED: begin
          // Green goes to the road that was not running before the walk.
          if (cnt_reg == PED_LAST) state_next = (ped_from_reg == FROM_Y2) ? ST_G1 : ST_G2;
        end
        ST_TURN_Y: begin
          if (cnt_reg == YELLOW_LAST) state_next = ST_TURN;
        end
        ST_TURN: begin
          if (cnt_reg == TURN_LAST) state_next = ST_G1;
        end
        ST_EMERG: begin
          if (ecnt_reg == EMERG_LAST) begin
            state_next = ST_AR2;
          end else begin
            ecnt_next = ecnt_reg + CNT_ONE;
            if (cnt_reg == FLASH_LAST) begin
              flash_next = ~flash_reg;
              cnt_next   = CNT_ZERO;
            end
          end
        end
        ST_OUTAGE: begin
          if (!bus.power_outage) begin
            state_next = ST_AR2;
          end else if (cnt_reg == FLASH_LAST) begin
            flash_next = ~flash_reg;
            cnt_next   = CNT_ZERO;
          end
        end
        default: state_next = ST_AR2;
      endcase
    end

    if (state_next != state_reg) cnt_next = CNT_ZERO;

    // A press on the very cycle PED is entered is kept for the next walk.
    ped_pending_next = ped_pending_reg;
    if ((state_next == ST_PED) && (state_reg != ST_PED)) ped_pending_next = 1'b0;
    if (bus.ped_req) ped_pending_next = 1'b1;
  end

  always_comb begin
    light1_next     = LAMP_RED;
    light2_next     = LAMP_RED;
    turn_light_next = 1'b0;
    ped_walk_next   = 1'b0;
    case (state_next)
      ST_G2:     light2_next = LAMP_GRN;
      ST_Y2:     light2_next = LAMP_YEL;
      ST_G1:     light1_next = LAMP_GRN;
      ST_Y1:     light1_next = LAMP_YEL;
      ST_PED:    ped_walk_next = 1'b1;
      ST_TURN_Y: light2_next = LAMP_YEL;
      ST_TURN:   turn_light_next = 1'b1;
      ST_EMERG: begin
        if (!flash_next) begin
          light1_next = LAMP_DARK;
          light2_next = LAMP_DARK;
        end
      end
      ST_OUTAGE: begin
        light1_next = flash_next ? LAMP_YEL : LAMP_DARK;
        light2_next = flash_next ? LAMP_YEL : LAMP_DARK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_AR2;
      cnt_reg         <= CNT_ZERO;
      ecnt_reg        <= CNT_ZERO;
      flash_reg       <= 1'b1;
      ped_pending_reg <= 1'b0;
      ped_from_reg    <= FROM_Y2;
      light1_reg      <= LAMP_RED;
      light2_reg      <= LAMP_RED;
      turn_light_reg  <= 1'b0;
      ped_walk_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      ecnt_reg        <= ecnt_next;
      flash_reg       <= flash_next;
      ped_pending_reg <= ped_pending_next;
      ped_from_reg    <= ped_from_next;
      light1_reg      <= light1_next;
      light2_reg      <= light2_next;
      turn_light_reg  <= turn_light_next;
      ped_walk_reg    <= ped_walk_next;
    end
  end

  assign bus.state      = state_reg;
  assign bus.light1     = light1_reg;
  assign bus.light2     = light2_reg;
  assign bus.turn_light = turn_light_reg;
  assign bus.ped_walk   = ped_walk_reg;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Scoreboard bench for traffic_ctrl_param: stimulus queues the expected outputs of each
// following cycle, a monitor process pops and compares them.
module tb_traffic_ctrl_param;

  localparam logic [3:0] S_G2     = 4'b0001;
  localparam logic [3:0] S_Y2     = 4'b0010;
  localparam logic [3:0] S_AR1    = 4'b0011;
  localparam logic [3:0] S_G1     = 4'b0100;
  localparam logic [3:0] S_Y1     = 4'b0101;
  localparam logic [3:0] S_AR2    = 4'b0110;
  localparam logic [3:0] S_PED    = 4'b0111;
  localparam logic [3:0] S_TURN_Y = 4'b1000;
  localparam logic [3:0] S_TURN   = 4'b1001;
  localparam logic [3:0] S_EMERG  = 4'b1010;
  localparam logic [3:0] S_OUTAGE = 4'b1011;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] l1;
    logic [2:0] l2;
    logic       tl;
    logic       pw;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_strobe = 1'b0;
  logic [0:9] fpat;
  obs_t exp_q[$];
  obs_t now_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  traffic_ctrl_param_if bus();

  traffic_ctrl_param #(
    .GREEN_CYC(8), .YELLOW_CYC(3), .ALLRED_CYC(2), .PED_CYC(6),
    .TURN_CYC(5), .FLASH_CYC(2), .EMERG_CYC(10), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Lamp table of the controller, keyed by state code and flash phase.
  function automatic obs_t expect_of(input logic [3:0] st, input logic fl);
    obs_t o;
    o.st = st; o.l1 = 3'b100; o.l2 = 3'b100; o.tl = 1'b0; o.pw = 1'b0;
    case (st)
      S_G2:     o.l2 = 3'b001;
      S_Y2:     o.l2 = 3'b010;
      S_G1:     o.l1 = 3'b001;
      S_Y1:     o.l1 = 3'b010;
      S_PED:    o.pw = 1'b1;
      S_TURN_Y: o.l2 = 3'b010;
      S_TURN:   o.tl = 1'b1;
      S_EMERG:  if (!fl) begin o.l1 = 3'b000; o.l2 = 3'b000; end
      S_OUTAGE: begin o.l1 = fl ? 3'b010 : 3'b000; o.l2 = o.l1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.st = bus.state; o.l1 = bus.light1; o.l2 = bus.light2;
    o.tl = bus.turn_light; o.pw = bus.ped_walk;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got st=%b l1=%b l2=%b turn=%b walk=%b, want st=%b l1=%b l2=%b turn=%b walk=%b",
               name, act.st, act.l1, act.l2, act.tl, act.pw, want.st, want.l1, want.l2, want.tl, want.pw);
    end else begin
      $display("%s: st=%b l1=%b l2=%b turn=%b walk=%b ok", name, act.st, act.l1, act.l2, act.tl, act.pw);
    end
  endtask

  // Monitor: per-cycle outputs after each clock edge, plus off-edge checks on strobe.
  initial begin : monitor
    obs_t want;
    forever begin
      @(posedge clk or posedge chk_strobe);
      #1;
      if (chk_strobe) begin
        if (now_q.size() > 0) begin
          want = now_q.pop_front();
          compare($sformatf("async t=%0t", $time), observed(), want);
        end
      end else begin
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          compare($sformatf("cycle %0d", cyc_no), observed(), want);
        end
        cyc_no++;
      end
    end
  end

  // Drive inputs for the current cycle; expect the given state in the next one.
  task automatic step(input logic e, input logic p, input logic pr, input logic lt,
                      input logic [3:0] st, input logic fl);
    bus.emergency = e; bus.power_outage = p; bus.ped_req = pr; bus.left_turn_req = lt;
    exp_q.push_back(expect_of(st, fl));
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, st, 1'b1);
  endtask

  task automatic check_now(input logic [3:0] st, input logic fl);
    now_q.push_back(expect_of(st, fl));
    chk_strobe = 1'b1;
    #2;
    chk_strobe = 1'b0;
  endtask

  initial begin : stimulus
    fpat = 10'b1100110011;
    bus.emergency = 1'b0; bus.power_outage = 1'b0; bus.ped_req = 1'b0; bus.left_turn_req = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_now(S_AR2, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Free-running cycle after reset release.
    idle(S_AR2, 1); idle(S_G2, 8); idle(S_Y2, 3); idle(S_AR1, 2); idle(S_G1, 8);
    idle(S_Y1, 3); idle(S_AR2, 2); idle(S_G2, 8); idle(S_Y2, 3); idle(S_AR1, 2);

    // Pedestrian pulse in the third G1 cycle, then a second pulse during the walk.
    idle(S_G1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0, S_G1, 1'b1);
    idle(S_Y1, 3); idle(S_PED, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, S_PED, 1'b1);
    idle(S_PED, 3); idle(S_G2, 2); idle(S_Y2, 3); idle(S_PED, 6);
    idle(S_G1, 8); idle(S_Y1, 3); idle(S_AR2, 2);

    // Left turn held from the second G2 cycle.
    idle(S_G2, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, S_TURN_Y, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, S_TURN, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, S_G1, 1'b1);
    idle(S_Y1, 3); idle(S_AR2, 2);

    // Left turn with a pending pedestrian request: the walk wins.
    idle(S_G2, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, S_G2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, S_Y2, 1'b1);
    idle(S_PED, 6);

    // One-cycle emergency pulse during G1.
    idle(S_G1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_EMERG, fpat[0]);
    for (int k = 1; k < 10; k++) step(1'b0, 1'b0, 1'b0, 1'b0, S_EMERG, fpat[k]);
    idle(S_AR2, 2); idle(S_G2, 1);

    // Emergency held 25 cycles: re-entry after a single AR2 cycle.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0, S_EMERG, fpat[k]);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR2, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0, S_EMERG, fpat[k]);
    step(1'b1, 1'b0, 1'b0, 1'b0, S_AR2, 1'b1);
    for (int k = 0; k < 10; k++) step((k < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, S_EMERG, fpat[k]);
    idle(S_AR2, 2); idle(S_G2, 1);

    // Outage for 9 cycles starting in Y2.
    idle(S_G2, 7); idle(S_Y2, 1);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 1'b0, S_OUTAGE, fpat[k]);
    step(1'b0, 1'b0, 1'b0, 1'b0, S_AR2, 1'b1);
    idle(S_AR2, 1); idle(S_G2, 1);

    // Emergency during outage; outage ignored while in emergency.
    step(1'b0, 1'b1, 1'b0, 1'b0, S_OUTAGE, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, S_OUTAGE, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, S_OUTAGE, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, S_EMERG, fpat[0]);
    for (int k = 1; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, S_EMERG, fpat[k]);
    step(1'b0, 1'b1, 1'b0, 1'b0, S_AR2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, S_OUTAGE, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, S_AR2, 1'b1);
    idle(S_AR2, 1); idle(S_G2, 1);

    // Asynchronous reset in the middle of TURN, with a pedestrian request latched.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, S_TURN_Y, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, S_TURN, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, S_TURN, 1'b1);
    bus.ped_req = 1'b0; bus.left_turn_req = 1'b0;
    #1 rst = 1'b1;
    check_now(S_AR2, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    // A full-length G2 shows the latched request was dropped by reset.
    idle(S_AR2, 1); idle(S_G2, 8); idle(S_Y2, 3); idle(S_AR1, 2); idle(S_G1, 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
- Parametrised two-road intersection controller with pedestrian, protected left-turn, emergency-flash and power-outage-flash modes.
- All phase durations are parameters in clock cycles; there is no internal clock divider, and timing is exact to the cycle.
- Pedestrian requests are latched so that short pulses are never lost.
- Sits between debounced push-button/sensor inputs and the lamp drivers.

Parameters:
- GREEN_CYC, 300, green phase length (cycles), >=2
- YELLOW_CYC, 50, yellow phase length, >=1
- ALLRED_CYC, 25, all-red clearance length, >=1
- PED_CYC, 600, pedestrian all-red walk length, >=1
- TURN_CYC, 300, protected left-turn length, >=1
- FLASH_CYC, 50, half-period of emergency/outage flashing, >=1
- EMERG_CYC, 300, total emergency-mode length, >=1
- CNT_W, 32, width of timer counters; must hold max(parameters)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- emergency  in  1  emergency request, level-sensitive
- power_outage  in  1  outage indication, level-sensitive
- ped_req  in  1  pedestrian button, pulse or level
- left_turn_req  in  1  left-turn sensor, level
- light1  out  3  road 1 lamp: 100 red, 010 yellow, 001 green, 000 dark
- light2  out  3  road 2 lamp, same encoding
- turn_light  out  1  protected left-turn arrow
- ped_walk  out  1  walk signal
- state  out  4  current state code, for debug/LEDs

Behaviour:
- Everything is a single clocked process. All outputs are registered and are a function of the state register plus the flash bit.
- The timer cnt counts 0..N-1 in each state. The transition happens on the cycle where cnt==N-1, so each state lasts exactly N cycles. cnt clears on every state change.
- Reset (async): state=AR2, cnt=0, ecnt=0, flash=1, ped_pending=0, light1=light2=100, turn_light=0, ped_walk=0.

State codes and lamp outputs (light1/light2):
- G2 0001: 100/001
- Y2 0010: 100/010
- AR1 0011: 100/100
- G1 0100: 001/100
- Y1 0101: 010/100
- AR2 0110: 100/100
- PED 0111: 100/100, ped_walk=1
- TURN_Y 1000: 100/010
- TURN 1001: 100/100, turn_light=1
- EMERG 1010: both 100 when flash=1, both 000 when flash=0
- OUTAGE 1011: both 010 when flash=1, both 000 when flash=0
- Any other code goes to AR2 on the next cycle.

Normal cycle: AR2 -> G2 -> Y2 -> AR1 -> G1 -> Y1 -> AR2.

ped_pending:
- Set on any cycle where ped_req=1.
- Cleared on the cycle PED is entered.
- Set has priority if ped_req is high on that same cycle, so the request is re-latched.

In G1/G2:
- If ped_pending=1, the green ends immediately and goes to Y1/Y2. This requires cnt>=1, i.e. at least one green cycle.

In Y1/Y2:
- On expiry, go to PED if ped_pending=1, else AR2/AR1.

PED:
- On expiry, hand green to the opposite road: entered from Y2 -> G1; entered from Y1 -> G2.
- A 1-bit `ped_from` register records the origin.

Left turn:
- In G2 only, when left_turn_req=1 and ped_pending=0: go to TURN_Y immediately.
- TURN_Y expiry (YELLOW_CYC) -> TURN.
- TURN expiry (TURN_CYC) -> G1.
- Pedestrian takes priority over left turn.

Priority, evaluated every cycle:
1. emergency: from any state other than EMERG -> EMERG, with ecnt=0 and flash=1.
2. power_outage: from any state other than EMERG or OUTAGE -> OUTAGE, with flash=1.
3. Timer and request transitions as above.

EMERG:
- flash toggles every FLASH_CYC cycles.
- After EMERG_CYC cycles total -> AR2.
- emergency still high at exit re-enters EMERG on the following cycle.
- power_outage is ignored while in EMERG.

OUTAGE:
- flash toggles every FLASH_CYC cycles while power_outage=1.
- The first cycle with power_outage=0 -> AR2.
- emergency overrides OUTAGE.

Requests:
- ped_pending is retained across EMERG and OUTAGE.
- left_turn_req is never latched.

Test Plan:
Parameters for all scenarios: GREEN=8, YELLOW=3, ALLRED=2, PED=6, TURN=5, FLASH=2, EMERG=10.

- Reset release with no inputs: state sequence AR2×2, G2×8, Y2×3, AR1×2, G1×8, Y1×3, AR2×2, then repeats (period 26). Lights match the table on every cycle.
- 1-cycle ped_req pulse during cycle 3 of G1: next cycle Y1×3, then PED×6 with ped_walk=1, then G2. ped_pending=0 after entering PED. A second pulse during PED yields another PED after the next yellow.
- left_turn_req held high from cycle 2 of G2: TURN_Y×3 (light2=010), TURN×5 (turn_light=1, both red), then G1×8. With ped_pending also set, PED is served instead.
- emergency pulsed 1 cycle during G1: EMERG for exactly 10 cycles with lights 100,100,000,000,100,100,... then AR2×2, then G2. emergency held for 25 cycles: EMERG re-entered; AR2 is never held more than 1 cycle before re-entry.
- power_outage high for 9 cycles from Y2: OUTAGE with lights 010/010 for 2 cycles, 000 for 2 cycles, alternating. Exits to AR2 the cycle after deassert. emergency asserted mid-outage switches to EMERG immediately.
- rst asserted asynchronously mid-TURN: outputs go to the reset values within the same cycle without waiting for a clock edge; turn_light=0, ped_pending=0.
